// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive buffer between the UART receiver and the CPU IO page.
//                Every byte flagged by the receiver's one-cycle done pulse is
//                written into a DEPTH-entry circular FIFO. The CPU reads a
//                data-pop register and a status register; both return their
//                value on rd_data_o one cycle after the strobe (registered),
//                matching the CPU's LOAD / WAIT_DATA sequence.
//
//  Ports       : clk_i        system clock
//                reset_i      synchronous, active-high reset
//                rx_valid_i   one-cycle pulse: rx_byte_i is valid
//                rx_byte_i    received byte
//                data_strb_i  IO read strobe, data register (pops one entry)
//                stat_strb_i  IO read strobe, status register (clears overrun)
//                rd_data_o    registered read data for the last strobe
//                rx_ready_o   FIFO non-empty (derived from registered state)
//
//  Data word   : [8] valid, [7:0] byte, rest 0
//  Status word : [15:8] count, [2] overrun, [1] full, [0] not-empty, rest 0
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        data_strb_i,
    input  logic        stat_strb_i,
    output logic [31:0] rd_data_o,
    output logic        rx_ready_o
);

    // Pointer width is derived from DEPTH and is not meant to be overridden.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic [31:0]   rd_data_q, rd_data_d;

    // ------------------------------------------------------------------------
    // Occupancy decisions. All of them use the pre-edge count, so a push and
    // a pop in the same cycle are judged against the state before the edge.
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_overflow;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_FULL_COUNT);

    // Data strobe wins over status strobe, so a pop only needs data_strb_i.
    assign w_pop      = data_strb_i && !w_empty;

    // When full, a simultaneous pop frees the slot at rp, which equals wp,
    // so the incoming byte can still be accepted without loss.
    assign w_push     = rx_valid_i && (!w_full || w_pop);
    assign w_overflow = rx_valid_i && w_full && !w_pop;

    // ------------------------------------------------------------------------
    // Count field of the status word: count zero-extended (or truncated for
    // very deep FIFOs) into an 8-bit field.
    // ------------------------------------------------------------------------
    logic [7:0] w_count_field;

    generate
        if (CW < 8) begin : g_count_ext
            assign w_count_field = {{(8 - CW){1'b0}}, count_q};
        end else if (CW == 8) begin : g_count_direct
            assign w_count_field = count_q;
        end else begin : g_count_trunc
            assign w_count_field = count_q[7:0];
        end
    endgenerate

    logic [31:0] w_status_word;
    logic [31:0] w_data_word;

    assign w_status_word = {16'b0, w_count_field, 5'b0, overrun_q, w_full, !w_empty};

    // An empty pop returns all zeros: bit 8 clear tells firmware "no byte".
    assign w_data_word   = w_pop ? {23'b0, 1'b1, mem_q[rp_q]} : 32'h0000_0000;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        rd_data_d = rd_data_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (w_push) begin
            wp_d = wp_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rp_d = rp_q + c_PTR_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase

        // Without any strobe the read register holds its last value so the
        // CPU can sample it in WAIT_DATA at its own pace.
        if (data_strb_i) begin
            rd_data_d = w_data_word;
        end else if (stat_strb_i) begin
            rd_data_d = w_status_word;
            overrun_d = 1'b0;
        end

        // A byte lost in the same cycle as a status read must not be hidden:
        // setting the flag takes precedence over the read-to-clear.
        if (w_overflow) begin
            overrun_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rd_data_q <= 32'h0000_0000;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array is intentionally not reset; pointers define validity.
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_push) begin
            mem_q[wp_q] <= rx_byte_i;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rd_data_o  = rd_data_q;
    assign rx_ready_o = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A behavioural queue
//                model predicts every read word; predictions are pushed to a
//                scoreboard when a strobe is driven and popped when the
//                registered result appears one edge later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        data_strb;
    logic        stat_strb;
    logic [31:0] rd_data;
    logic        rx_ready;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rx_valid_i  (rx_valid),
        .rx_byte_i   (rx_byte),
        .data_strb_i (data_strb),
        .stat_strb_i (stat_strb),
        .rd_data_o   (rd_data),
        .rx_ready_o  (rx_ready)
    );

    // Reference model and scoreboard
    logic [7:0]  model_q[$];
    logic        model_ovr;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle of stimulus with model update and post-edge checks.
    task automatic step(input logic rxv, input logic [7:0] b, input logic ds, input logic ss);
        logic [31:0] e;
        logic        m_full, m_empty, m_pop, m_push, m_ovf;
        @(negedge clk);
        rx_valid  = rxv;
        rx_byte   = b;
        data_strb = ds;
        stat_strb = ss;

        m_empty = (model_q.size() == 0);
        m_full  = (model_q.size() == DEPTH);
        if (ds) begin
            e = m_empty ? 32'h0 : {23'b0, 1'b1, model_q[0]};
            exp_q.push_back(e);
        end else if (ss) begin
            e = {16'b0, 8'(model_q.size()), 5'b0, model_ovr, m_full, !m_empty};
            exp_q.push_back(e);
        end
        m_pop  = ds && !m_empty;
        m_push = rxv && (!m_full || m_pop);
        m_ovf  = rxv && m_full && !m_pop;
        if (m_pop)  void'(model_q.pop_front());
        if (m_push) model_q.push_back(b);
        if (ss && !ds) model_ovr = 1'b0;
        if (m_ovf)     model_ovr = 1'b1;

        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        data_strb = 1'b0;
        stat_strb = 1'b0;
        if (ds || ss) begin
            e = exp_q.pop_front();
            last_rd = e;
            check("rd_data", rd_data, e);
        end else begin
            check("rd_hold", rd_data, last_rd);
        end
        check("rx_ready", {31'b0, rx_ready}, {31'b0, model_q.size() != 0});
    endtask

    // Synchronous reset with all other inputs active; they must be ignored.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        rx_valid  = 1'b1;
        rx_byte   = 8'hEE;
        data_strb = 1'b1;
        stat_strb = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        rx_valid  = 1'b0;
        data_strb = 1'b0;
        stat_strb = 1'b0;
        model_q.delete();
        exp_q.delete();
        model_ovr = 1'b0;
        last_rd   = 32'h0;
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_rx_ready", {31'b0, rx_ready}, 32'h0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        data_strb = 1'b0;
        stat_strb = 1'b0;
        model_ovr = 1'b0;
        last_rd   = 32'h0;

        // Reset state and reads of an empty FIFO
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("empty_pop", rd_data, 32'h0000_0000);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("empty_status", rd_data, 32'h0000_0000);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Three bytes in, status, three pops, one empty pop
        step(1'b1, 8'h41, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("status_3", rd_data, 32'h0000_0301);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("pop_abc", rd_data, 32'h141 + 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_after_drain", rd_data, 32'h0);
        check("ready_after_drain", {31'b0, rx_ready}, 32'h0);

        // Overflow: 17 bytes into 16 entries
        for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("status_overrun", rd_data, 32'h0000_1007);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("status_cleared", rd_data, 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("pop_full", rd_data, 32'h100 + 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("byte_0x10_lost", rd_data, 32'h0);

        // Push and pop on an empty FIFO in the same cycle
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("empty_push_pop", rd_data, 32'h0);
        check("empty_push_pop_ready", {31'b0, rx_ready}, 32'h1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_0x55", rd_data, 32'h155);

        // Push and pop on a full FIFO in the same cycle
        for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("full_push_pop", rd_data, 32'h120);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("full_no_overrun", rd_data, 32'h0000_1003);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("last_pop_0xAA", rd_data, 32'h1AA);

        // Mixed traffic across several pointer wraps
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-stream with 5 bytes buffered and overrun set
        for (int i = 0; i <= 16; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("status_after_reset", rd_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the UART receiver and the CPU's memory-mapped IO page. Captures every byte the receiver flags with its one-cycle done pulse into a DEPTH-entry circular FIFO so firmware polling at instruction rate loses no characters. Exposes a data-pop register and a status register to the IO read path; both are read with registered, one-cycle latency, matching the CPU's LOAD/WAIT_DATA sequence.

## Interface
- DEPTH, 16: number of byte entries; power of two, at least 2.
- AW, $clog2(DEPTH): pointer width (derived, not overridden).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse from the receiver: rx_byte is valid.
- rx_byte  in  8  received byte.
- data_strb  in  1  IO read strobe for the data register; pops one entry.
- stat_strb  in  1  IO read strobe for the status register; clears overrun.
- rd_data  out  32  registered read data for the last strobe.
- rx_ready  out  1  FIFO non-empty (registered-state derived, no input path).

## Operation
- Storage: DEPTH x 8 array, write pointer wp, read pointer rp (AW bits each, wrap DEPTH-1 -> 0 naturally), count (AW+1 bits, 0..DEPTH), sticky overrun flag.
- Push: on a clock edge with rx_valid=1 and count<DEPTH, mem[wp] <= rx_byte, wp <= wp+1.
- Push when full (count==DEPTH, no pop the same cycle): byte dropped, overrun <= 1, wp/count unchanged.
- Pop: on a clock edge with data_strb=1 and count>0: rd_data <= {23'b0, 1'b1, mem[rp]}, rp <= rp+1.
- Pop when empty: rd_data <= 32'h0000_0000 (bit 8 = 0 means no byte); no pointer change.
- Status read: on edge with stat_strb=1: rd_data <= {16'b0, 3'b0, count[4:0] zero-extended/truncated to count's width in bits [15:8], 5'b0, overrun, full, !empty}; overrun <= 0 unless an overflowing push occurs in the same cycle (set wins).
- Data word layout: bits[7:0] byte, bit 8 valid. Status layout: bit0 not-empty, bit1 full, bit2 overrun, bits[15:8] count, rest 0.
- data_strb and stat_strb both high: data_strb takes priority for rd_data and pop; overrun not cleared.
- Neither strobe: rd_data holds.
- Simultaneous push and pop: empty/full decisions use pre-edge count. Empty + push + pop: pop returns valid=0, byte stored, count 0->1. Full + push + pop: both occur, no overrun, count stays DEPTH, written slot is the one just freed (wp==rp pre-edge).
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- rx_ready = (count != 0); full = (count == DEPTH).

## Timing
- Reset (synchronous): wp=0, rp=0, count=0, overrun=0, rd_data=0, rx_ready=0. Array contents not reset. Reset asserted mid-stream discards all buffered bytes; strobes and rx_valid ignored during the reset cycle.
- Push latency: rx_valid at edge N -> rx_ready/count updated after edge N; a data_strb sampled at edge N+1 returns that byte.
- Read latency: strobe sampled at edge N -> rd_data valid after edge N, held until the next strobe edge (CPU samples it in WAIT_DATA).
- Strobes are level-sampled per cycle: two consecutive cycles of data_strb pop two entries.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, then data_strb -> rd_data=0x000, stat_strb -> rd_data=0x00000001? no: 0x00000000, rx_ready=0.
- Push 0x41,0x42,0x43; stat_strb -> rd_data=0x00000301; three data_strb -> 0x141,0x142,0x143; fourth -> 0x000, rx_ready=0.
- Push 17 bytes 0x00..0x10 (DEPTH=16) -> status 0x00001007 (count 16, overrun, full, non-empty); next status read 0x00001003; pops return 0x100..0x10F, 0x10 lost.
- Empty FIFO, rx_valid=1 with 0x55 and data_strb same cycle -> rd_data=0x000, count=1; next data_strb -> 0x155.
- Full FIFO, rx_valid 0xAA with data_strb same cycle -> pop returns oldest, count stays 16, overrun=0; after draining, last pop returns 0x1AA; pointers wrap correctly over 40 push/pop cycles.
- Reset asserted with 5 bytes buffered and overrun set -> next cycle rx_ready=0, status read 0x00000000.
